dct_coef_link: RTL and testbench

- Parametrised inter-stage link between the dct and idct blocks. It takes the forward-transform coefficient stream, reduces each word to KEEP_W MSBs (truncate, or round with ROUND_EN), and sign-extends it to OUT_W.
- It double-buffers whole blocks of DEPTH coefficients so the dct and idct can run decoupled.
- It generates the idct precision-select (rapx) from a free-running cycle counter and a programmable window.
- It replaces the fixed 12-bit slice and fixed rapx toggling used until now.

---
 rtl/dct_link_pkg.sv | 54 +++++
 rtl/dct_link_bank.sv | 52 +++++
 rtl/dct_coef_link.sv | 238 +++++++++++++++++++++++
 tb/tb_dct_coef_link.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_link_pkg.sv
// dct_link_pkg: shared types, constants and the coefficient reduction helper for dct_coef_link.
//
// Contents:
//   MAX_W       - widest intermediate word handled by coef_reduce
//   DEF_DEPTH   - default block length (coefficients per block)
//   DEPTH_W     - index width for a DEF_DEPTH block
//   rd_state_e  - read-side FSM states
//   coef_reduce - keep the KEEP_W MSBs of an IN_W word (truncate, or round half away from
//                 zero when DCT_COEF_LINK_ROUND_EN is defined)
//
// Configuration macro: DCT_COEF_LINK_ROUND_EN (undefined: plain floor truncation).
package dct_link_pkg;

   localparam int unsigned MAX_W     = 64;
   localparam int unsigned DEF_DEPTH = 64;
   localparam int unsigned DEPTH_W   = $clog2(DEF_DEPTH);

   typedef enum logic {
      RD_IDLE,
      RD_STREAM
   } rd_state_e;

   // x is the IN_W coefficient sign-extended to MAX_W. The result is the kept value,
   // sign-extended to MAX_W; callers take the low keep_w bits.
   function automatic logic [MAX_W-1:0] coef_reduce(input logic [MAX_W-1:0] x,
                                                    input int unsigned       in_w,
                                                    input int unsigned       keep_w);
`ifdef DCT_COEF_LINK_ROUND_EN
      logic             neg;
      logic [MAX_W-1:0] mag;
      logic [MAX_W-1:0] rnd;
      logic [MAX_W-1:0] lim;
`endif
      int unsigned sh;
      sh = in_w - keep_w;
`ifdef DCT_COEF_LINK_ROUND_EN
      if (sh == 0) begin
         return x;
      end
      neg = x[MAX_W-1];
      mag = neg ? (~x + MAX_W'(1)) : x;
      rnd = (mag + (MAX_W'(1) << (sh - 1))) >> sh;
      lim = (MAX_W'(1) << (keep_w - 1)) - MAX_W'(1);
      // Only the positive side can overflow; -2^(keep_w-1) is representable.
      if (!neg && (rnd > lim)) begin
         rnd = lim;
      end
      return neg ? (~rnd + MAX_W'(1)) : rnd;
`else
      return MAX_W'($signed(x) >>> sh);
`endif
   endfunction

endpackage

// File: rtl/dct_link_bank.sv
// dct_link_bank: one DEPTH x KEEP_W coefficient bank with its full flag.
//
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset (clears the full flag only)
//   we, waddr, wdata   - single write port
//   raddr, rdata       - single asynchronous read port
//   set_full, clr_full - full flag set (block written) / clear (block drained)
//   full               - bank holds a complete, not yet drained block
module dct_link_bank
   import dct_link_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned KEEP_W = 12,
   parameter int unsigned IDX_W  = $clog2(DEF_DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [KEEP_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [KEEP_W-1:0] rdata,
   input  logic              set_full,
   input  logic              clr_full,
   output logic              full
);

   logic [KEEP_W-1:0] mem [DEPTH];
   logic              full_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

   // set and clr never target the same bank in one cycle: a bank is writable only when empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_q <= 1'b0;
      end else if (set_full) begin
         full_q <= 1'b1;
      end else if (clr_full) begin
         full_q <= 1'b0;
      end
   end

   assign full = full_q;

endmodule

// File: rtl/dct_coef_link.sv
// dct_coef_link: double-buffered link from the dct coefficient stream to the idct.
//
// Each IN_W coefficient is reduced to its KEEP_W MSBs, stored in one of two DEPTH-word banks,
// and streamed out block-wise sign-extended to OUT_W. A free-running saturating cycle counter
// drives the idct precision select rapx through a programmable exclusive window.
//
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   in_valid, in_data, in_ready   - coefficient input (words offered while !in_ready are dropped)
//   out_valid, out_ready,
//   out_data, out_first           - block output stream; out_first marks word 0 (idct start)
//   apx_en, apx_lo, apx_hi        - rapx window enable and exclusive bounds
//   rapx                          - registered idct approximate-mode select
//   ovf                           - sticky: an input word was dropped
//   blk_cnt                       - number of fully drained blocks (wraps)
//
// Configuration macro: DCT_COEF_LINK_ROUND_EN selects round-half-away-from-zero reduction.
module dct_coef_link
   import dct_link_pkg::*;
#(
   parameter int unsigned IN_W   = 32,
   parameter int unsigned KEEP_W = 12,
   parameter int unsigned OUT_W  = 32,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_first,
   input  logic             apx_en,
   input  logic [CNT_W-1:0] apx_lo,
   input  logic [CNT_W-1:0] apx_hi,
   output logic             rapx,
   output logic             ovf,
   output logic [15:0]      blk_cnt
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   if ((KEEP_W < 2) || (KEEP_W > IN_W) || (OUT_W < KEEP_W) || (IN_W > MAX_W) ||
       (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
      $error("dct_coef_link: illegal parameter combination");
   end

   // ---------------------------------------------------------------------------------------
   // Write side
   // ---------------------------------------------------------------------------------------
   logic             wr_bank_q;
   logic [IDX_W-1:0] wr_idx_q;
   logic             ovf_q;
   logic [1:0]       full;
   logic             wr_fire;
   logic             wr_last;

   logic [MAX_W-1:0]  in_ext;
   logic [MAX_W-1:0]  red;
   logic [KEEP_W-1:0] wr_data;
   logic              unused_red;

   assign in_ready = !full[wr_bank_q];
   assign wr_fire  = in_valid && in_ready;
   assign wr_last  = wr_fire && (wr_idx_q == LAST_IDX);

   always_comb begin
      in_ext            = {MAX_W{in_data[IN_W-1]}};
      in_ext[IN_W-1:0]  = in_data;
   end

   assign red        = coef_reduce(in_ext, IN_W, KEEP_W);
   assign wr_data    = red[KEEP_W-1:0];
   assign unused_red = ^(red >> KEEP_W);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (wr_last) begin
               wr_bank_q <= ~wr_bank_q;
            end
         end
         if (in_valid && !in_ready) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Banks
   // ---------------------------------------------------------------------------------------
   rd_state_e         state_q;
   logic              rd_bank_q;
   logic [IDX_W-1:0]  rd_idx_q;
   logic [IDX_W-1:0]  rd_addr;
   logic              rd_last;
   logic              rd_sel;
   logic [KEEP_W-1:0] rdata_a;
   logic [KEEP_W-1:0] rdata_b;
   logic [KEEP_W-1:0] rd_word;
   logic [OUT_W-1:0]  out_ext;

   // Read address points at the word to load next; at a block end it wraps to 0, which is
   // word 0 of the other bank when streaming continues back to back.
   assign rd_addr = (state_q == RD_STREAM) ? (rd_idx_q + IDX_W'(1)) : '0;
   assign rd_last = (state_q == RD_STREAM) && out_valid && out_ready && (rd_idx_q == LAST_IDX);
   assign rd_sel  = rd_last ? ~rd_bank_q : rd_bank_q;
   assign rd_word = rd_sel ? rdata_b : rdata_a;

   always_comb begin
      out_ext              = {OUT_W{rd_word[KEEP_W-1]}};
      out_ext[KEEP_W-1:0]  = rd_word;
   end

   dct_link_bank #(
      .DEPTH  (DEPTH),
      .KEEP_W (KEEP_W),
      .IDX_W  (IDX_W)
   ) u_bank_a (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (wr_fire && !wr_bank_q),
      .waddr    (wr_idx_q),
      .wdata    (wr_data),
      .raddr    (rd_addr),
      .rdata    (rdata_a),
      .set_full (wr_last && !wr_bank_q),
      .clr_full (rd_last && !rd_bank_q),
      .full     (full[0])
   );

   dct_link_bank #(
      .DEPTH  (DEPTH),
      .KEEP_W (KEEP_W),
      .IDX_W  (IDX_W)
   ) u_bank_b (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (wr_fire && wr_bank_q),
      .waddr    (wr_idx_q),
      .wdata    (wr_data),
      .raddr    (rd_addr),
      .rdata    (rdata_b),
      .set_full (wr_last && wr_bank_q),
      .clr_full (rd_last && rd_bank_q),
      .full     (full[1])
   );

   // ---------------------------------------------------------------------------------------
   // Read FSM with registered outputs
   // ---------------------------------------------------------------------------------------
   logic [OUT_W-1:0] out_data_q;
   logic             out_valid_q;
   logic             out_first_q;
   logic [15:0]      blk_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RD_IDLE;
         rd_bank_q   <= 1'b0;
         rd_idx_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         blk_cnt_q   <= '0;
      end else begin
         unique case (state_q)
            RD_IDLE: begin
               if (full[rd_bank_q]) begin
                  out_data_q  <= out_ext;
                  out_valid_q <= 1'b1;
                  out_first_q <= 1'b1;
                  rd_idx_q    <= '0;
                  state_q     <= RD_STREAM;
               end
            end
            RD_STREAM: begin
               if (out_valid_q && out_ready) begin
                  if (rd_idx_q == LAST_IDX) begin
                     rd_bank_q <= ~rd_bank_q;
                     rd_idx_q  <= '0;
                     blk_cnt_q <= blk_cnt_q + 16'd1;
                     if (full[~rd_bank_q]) begin
                        out_data_q  <= out_ext;
                        out_first_q <= 1'b1;
                     end else begin
                        out_valid_q <= 1'b0;
                        out_first_q <= 1'b0;
                        state_q     <= RD_IDLE;
                     end
                  end else begin
                     rd_idx_q    <= rd_idx_q + IDX_W'(1);
                     out_data_q  <= out_ext;
                     out_first_q <= 1'b0;
                  end
               end
            end
            default: state_q <= RD_IDLE;
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign blk_cnt   = blk_cnt_q;
   assign ovf       = ovf_q;

   // ---------------------------------------------------------------------------------------
   // rapx window: saturating cycle counter and exclusive window compare
   // ---------------------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q;
   logic             rapx_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         rapx_q <= 1'b0;
      end else begin
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         rapx_q <= apx_en && (cnt_q > apx_lo) && (cnt_q < apx_hi);
      end
   end

   assign rapx = rapx_q;

endmodule

// File: tb/tb_dct_coef_link.sv
// Scoreboard bench for dct_coef_link at default parameters (32/12/32, DEPTH 64).
module tb_dct_coef_link;

   localparam int IN_W   = 32;
   localparam int KEEP_W = 12;
   localparam int OUT_W  = 32;
   localparam int DEPTH  = 64;
   localparam int CNT_W  = 32;
   localparam int SH     = IN_W - KEEP_W;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic             out_first;
   logic             apx_en = 1'b0;
   logic [CNT_W-1:0] apx_lo = '0;
   logic [CNT_W-1:0] apx_hi = '0;
   logic             rapx;
   logic             ovf;
   logic [15:0]      blk_cnt;

   dct_coef_link #(
      .IN_W   (IN_W),
      .KEEP_W (KEEP_W),
      .OUT_W  (OUT_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_first (out_first),
      .apx_en    (apx_en),
      .apx_lo    (apx_lo),
      .apx_hi    (apx_hi),
      .rapx      (rapx),
      .ovf       (ovf),
      .blk_cnt   (blk_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [32:0] sb[$];   // {first, data}
   int          acc_cnt = 0;
   bit          sends_done;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference reduction, written directly from the numeric definition.
   function automatic logic [31:0] model(input logic [31:0] d);
      longint x;
      longint r;
      x = longint'($signed(d));
`ifdef DCT_COEF_LINK_ROUND_EN
      if (x >= 0) begin
         r = (x + (64'sd1 <<< (SH - 1))) / (64'sd1 <<< SH);
         if (r > (64'sd1 <<< (KEEP_W - 1)) - 1) r = (64'sd1 <<< (KEEP_W - 1)) - 1;
      end else begin
         r = -((-x + (64'sd1 <<< (SH - 1))) / (64'sd1 <<< SH));
      end
`else
      r = x >>> SH;
`endif
      return 32'(r);
   endfunction

   // Start at posedge+1; returns at posedge+1 after the word's sampling edge.
   task automatic drive(input logic [31:0] d, input bit expect_acc);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      check_eq("in_ready", 64'(in_ready), 64'(expect_acc));
      if (expect_acc) begin
         sb.push_back({(acc_cnt % DEPTH) == 0, model(d)});
         acc_cnt++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      check_eq("drain_timeout", 64'(sb.size()), 64'(0));
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check_eq("rst_in_ready", 64'(in_ready), 64'(1));
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_out_first", 64'(out_first), 64'(0));
      check_eq("rst_out_data", 64'(out_data), 64'(0));
      check_eq("rst_rapx", 64'(rapx), 64'(0));
      check_eq("rst_ovf", 64'(ovf), 64'(0));
      check_eq("rst_blk_cnt", 64'(blk_cnt), 64'(0));
      sb.delete();
      acc_cnt = 0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard compare on accept, stability while stalled.
   logic             prev_stall = 1'b0;
   logic [OUT_W-1:0] prev_data;
   logic             prev_first;
   logic [32:0]      exp_w;

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("stall_data", 64'(out_data), 64'(prev_data));
            check_eq("stall_first", 64'(out_first), 64'(prev_first));
            check_eq("stall_valid", 64'(out_valid), 64'(1));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("spurious_valid", 64'(out_valid), 64'(0));
            end else begin
               exp_w = sb.pop_front();
               check_eq("out_data", 64'(out_data), 64'(exp_w[31:0]));
               check_eq("out_first", 64'(out_first), 64'(exp_w[32]));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_first = out_first;
      end
   end

   initial begin
      do_reset();

      // Fill and drain one block; also check the two-cycle latency to word 0.
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         drive(32'(i) << 20, 1'b1);
      end
      @(negedge clk);
      check_eq("lat_valid_early", 64'(out_valid), 64'(0));
      @(negedge clk);
      check_eq("lat_valid", 64'(out_valid), 64'(1));
      check_eq("lat_first", 64'(out_first), 64'(1));
      wait_drain(200);
      check_eq("t1_blk_cnt", 64'(blk_cnt), 64'(1));
      check_eq("t1_ovf", 64'(ovf), 64'(0));

      // Sign extension and rounding corners, rest random.
      drive(32'h8010_0000, 1'b1);
      drive(32'h8000_0000, 1'b1);
      drive(32'h7FFF_FFFF, 1'b1);
      drive(32'hFFF8_0000, 1'b1);
      drive(32'h0008_0000, 1'b1);
      drive(32'hFFF7_FFFF, 1'b1);
      for (int i = 6; i < DEPTH; i++) begin
         drive($urandom, 1'b1);
      end
      wait_drain(200);
      check_eq("t2_blk_cnt", 64'(blk_cnt), 64'(2));

      // Back-pressure: three blocks offered, the third is dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         drive(32'(i * 7919) << 12, i < 2 * DEPTH);
      end
      check_eq("t3_ovf", 64'(ovf), 64'(1));
      check_eq("t3_blk_cnt_held", 64'(blk_cnt), 64'(2));
      check_eq("t3_out_valid", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      wait_drain(400);
      check_eq("t3_blk_cnt", 64'(blk_cnt), 64'(4));
      check_eq("t3_in_ready", 64'(in_ready), 64'(1));

      // Stall mid-block: out_ready toggles 1010... while filling and draining.
      sends_done = 1'b0;
      fork
         begin
            for (int i = 0; i < DEPTH; i++) begin
               drive($urandom, 1'b1);
            end
            sends_done = 1'b1;
         end
         begin
            int k = 0;
            while (!(sends_done && sb.size() == 0) && k < 600) begin
               @(posedge clk);
               #1;
               out_ready = ~out_ready;
               k++;
            end
         end
      join
      out_ready = 1'b1;
      wait_drain(50);
      check_eq("t4_blk_cnt", 64'(blk_cnt), 64'(5));

      // Reset mid-block discards the partial block.
      for (int i = 0; i < 30; i++) begin
         drive(32'(i + 100) << 20, 1'b1);
      end
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(32'(DEPTH - 1 - i) << 20, 1'b1);
      end
      wait_drain(200);
      check_eq("t6_blk_cnt", 64'(blk_cnt), 64'(1));
      check_eq("t6_ovf", 64'(ovf), 64'(0));

      // rapx window 10..20 exclusive, counted from reset release.
      @(negedge clk);
      reset_n = 1'b0;
      apx_en  = 1'b1;
      apx_lo  = 32'd10;
      apx_hi  = 32'd20;
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         check_eq("rapx_win", 64'(rapx), 64'(((k - 1) > 10) && ((k - 1) < 20)));
      end
      // Inverted window never asserts.
      @(negedge clk);
      reset_n = 1'b0;
      apx_lo  = 32'd20;
      apx_hi  = 32'd10;
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         check_eq("rapx_inv", 64'(rapx), 64'(0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
